// File: rtl/pd_tdl_pkg.sv
// Shared FSM encoding, default parameters and helper functions for the
// hybrid tapped-delay-line phase detector.
package pd_tdl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_SECOND = 2'd1,
    ST_RESULT      = 2'd2
  } pd_state_e;

  localparam int unsigned FINE_TAPS_DEF    = 15;
  localparam int unsigned COARSE_WIDTH_DEF = 6;
  localparam int unsigned TIMEOUT_DEF      = 63;
  localparam int unsigned WIDTH_DEF        = 12;
  localparam int unsigned POP_MAX          = 64;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res++;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Counting ones rather than locating the transition tolerates bubbles.
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] vec);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < int'(POP_MAX); i++) begin
      if (vec[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdl_capture_line.sv
// One delay line: buffer chain of inverter pairs, snapshot register,
// metastability register and rising-edge / fine-value extraction.
module tdl_capture_line
  import pd_tdl_pkg::*;
#(
  parameter  int unsigned FINE_TAPS = FINE_TAPS_DEF,
  localparam int unsigned FW        = clog2(FINE_TAPS + 1)
) (
  input  logic          fpga_clk_i,
  input  logic          reset_i,
  input  logic          din_i,
  output logic          event_c,
  output logic [FW-1:0] fine_c
);

  logic [FINE_TAPS:1] taps;
  (* dont_touch = "true" *) logic [FINE_TAPS:1] snap_q;
  logic [FINE_TAPS:1] snap_d;
  logic [FINE_TAPS:1] sync_q;
  logic [FINE_TAPS:1] sync_d;
  logic               prev_q;
  logic               prev_d;

  // Each stage is its own net so the chain is not a self-referencing vector.
  for (genvar i = 1; i <= FINE_TAPS; i++) begin : g_tap
    (* dont_touch = "true" *) logic inv_n;
    (* dont_touch = "true" *) logic tap;
    if (i == 1) begin : g_first
      assign inv_n = ~din_i;
    end else begin : g_next
      assign inv_n = ~g_tap[i-1].tap;
    end
    assign tap     = ~inv_n;
    assign taps[i] = tap;
  end

  always_comb begin
    snap_d = taps;
    sync_d = snap_q;
    prev_d = sync_q[1];
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      snap_q <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      snap_q <= snap_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign event_c = sync_q[1] & ~prev_q;
  assign fine_c  = FW'(popcount(POP_MAX'(sync_q)));

endmodule

// File: rtl/phase_detector_tdl_hybrid.sv
// Hybrid coarse-counter / fine-TDL phase detector between a reference and a
// generated clock; reports signed error in tap units.
module phase_detector_tdl_hybrid
  import pd_tdl_pkg::*;
#(
  parameter int unsigned FINE_TAPS    = FINE_TAPS_DEF,
  parameter int unsigned COARSE_WIDTH = COARSE_WIDTH_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned WIDTH        = WIDTH_DEF
) (
  input  logic                    fpga_clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    reference_i,
  input  logic                    generated_i,
  output logic signed [WIDTH-1:0] pd_error_o,
  output logic                    pd_valid_o,
  output logic                    pd_timeout_o,
  output logic                    pd_busy_o
);

  localparam int unsigned FW = clog2(FINE_TAPS + 1);
  localparam int unsigned CW = COARSE_WIDTH;
  localparam int unsigned EW = max2(WIDTH + 2, CW + FW + 2);
  localparam logic signed [EW-1:0] TAPS_S  = EW'(FINE_TAPS);
  localparam logic signed [EW-1:0] SAT_MAX = EW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic          ref_evt_c;
  logic          gen_evt_c;
  logic [FW-1:0] ref_fine_c;
  logic [FW-1:0] gen_fine_c;

  tdl_capture_line #(.FINE_TAPS(FINE_TAPS)) u_ref_line (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .din_i      (reference_i),
    .event_c    (ref_evt_c),
    .fine_c     (ref_fine_c)
  );

  tdl_capture_line #(.FINE_TAPS(FINE_TAPS)) u_gen_line (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .din_i      (generated_i),
    .event_c    (gen_evt_c),
    .fine_c     (gen_fine_c)
  );

  pd_state_e               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    ref_first_q, ref_first_d;
  logic [FW-1:0]           fine_ref_q, fine_ref_d;
  logic [FW-1:0]           fine_gen_q, fine_gen_d;
  logic signed [CW:0]      coarse_q, coarse_d;
  logic signed [WIDTH-1:0] error_q, error_d;
  logic                    valid_q, valid_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;

  logic [CW-1:0]           elapsed_c;
  logic signed [EW-1:0]    err_full_c;
  logic signed [WIDTH-1:0] err_sat_c;

  // Cycles since the first event, counting the current one.
  assign elapsed_c = cnt_q + 1'b1;

  // Wide error then saturation to the output range.
  always_comb begin
    err_full_c = EW'(coarse_q) * TAPS_S
               + EW'($signed({1'b0, fine_ref_q}))
               - EW'($signed({1'b0, fine_gen_q}));
    if (err_full_c > SAT_MAX) begin
      err_sat_c = WIDTH'(SAT_MAX);
    end else if (err_full_c < SAT_MIN) begin
      err_sat_c = WIDTH'(SAT_MIN);
    end else begin
      err_sat_c = WIDTH'(err_full_c);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ref_first_d = ref_first_q;
    fine_ref_d  = fine_ref_q;
    fine_gen_d  = fine_gen_q;
    coarse_d    = coarse_q;
    error_d     = error_q;
    valid_d     = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ref_evt_c && gen_evt_c) begin
          fine_ref_d = ref_fine_c;
          fine_gen_d = gen_fine_c;
          coarse_d   = '0;
          state_d    = ST_RESULT;
        end else if (ref_evt_c) begin
          ref_first_d = 1'b1;
          fine_ref_d  = ref_fine_c;
          cnt_d       = '0;
          state_d     = ST_WAIT_SECOND;
        end else if (gen_evt_c) begin
          ref_first_d = 1'b0;
          fine_gen_d  = gen_fine_c;
          cnt_d       = '0;
          state_d     = ST_WAIT_SECOND;
        end
      end
      ST_WAIT_SECOND: begin
        cnt_d = elapsed_c;
        if (ref_first_q && gen_evt_c) begin
          fine_gen_d = gen_fine_c;
          coarse_d   = $signed({1'b0, elapsed_c});
          state_d    = ST_RESULT;
        end else if (!ref_first_q && ref_evt_c) begin
          fine_ref_d = ref_fine_c;
          coarse_d   = -$signed({1'b0, elapsed_c});
          state_d    = ST_RESULT;
        end else if (elapsed_c == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_RESULT: begin
        error_d = err_sat_c;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Disarming abandons any measurement without reporting it.
    if (!enable_i) begin
      state_d   = ST_IDLE;
      error_d   = error_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;
    end

    busy_d = (state_d == ST_WAIT_SECOND);
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ref_first_q <= 1'b0;
      fine_ref_q  <= '0;
      fine_gen_q  <= '0;
      coarse_q    <= '0;
      error_q     <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ref_first_q <= ref_first_d;
      fine_ref_q  <= fine_ref_d;
      fine_gen_q  <= fine_gen_d;
      coarse_q    <= coarse_d;
      error_q     <= error_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign pd_error_o   = error_q;
  assign pd_valid_o   = valid_q;
  assign pd_timeout_o = timeout_q;
  assign pd_busy_o    = busy_q;

endmodule

// File: tb/tb_phase_detector_tdl_hybrid.sv
// Directed bench: edge positions inside the delay lines are imposed by forcing
// the tap nets for the snapshot cycle; expected errors are hand-computed.
module tb_phase_detector_tdl_hybrid;

  localparam int unsigned FT = 15;

  logic clk = 1'b0;
  logic reset_i;
  logic enable_i;
  logic reference_i;
  logic generated_i;

  logic signed [11:0] err12;
  logic               valid12, tmo12, busy12;
  logic signed [7:0]  err8;
  logic               valid8, tmo8, busy8;

  logic [FT:1] ref_pat;
  logic [FT:1] gen_pat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  phase_detector_tdl_hybrid dut (
    .fpga_clk_i   (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .reference_i  (reference_i),
    .generated_i  (generated_i),
    .pd_error_o   (err12),
    .pd_valid_o   (valid12),
    .pd_timeout_o (tmo12),
    .pd_busy_o    (busy12)
  );

  phase_detector_tdl_hybrid #(.WIDTH(8)) dut8 (
    .fpga_clk_i   (clk),
    .reset_i      (reset_i),
    .enable_i     (enable_i),
    .reference_i  (reference_i),
    .generated_i  (generated_i),
    .pd_error_o   (err8),
    .pd_valid_o   (valid8),
    .pd_timeout_o (tmo8),
    .pd_busy_o    (busy8)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [FT:1] therm(input int f);
    logic [FT:1] v;
    for (int i = 1; i <= int'(FT); i++) v[i] = (i <= f);
    return v;
  endfunction

  // Thermometer of f ones in the taps nearest the input at the next snapshot.
  task fire_ref(input int f);
    ref_pat = therm(f);
    force dut.u_ref_line.taps = ref_pat;
    force dut8.u_ref_line.taps = ref_pat;
    reference_i = 1'b1;
  endtask

  task unfire_ref();
    release dut.u_ref_line.taps;
    release dut8.u_ref_line.taps;
  endtask

  task fire_gen(input int f);
    gen_pat = therm(f);
    force dut.u_gen_line.taps = gen_pat;
    force dut8.u_gen_line.taps = gen_pat;
    generated_i = 1'b1;
  endtask

  task unfire_gen();
    release dut.u_gen_line.taps;
    release dut8.u_gen_line.taps;
  endtask

  task automatic lower();
    reference_i = 1'b0;
    generated_i = 1'b0;
    tick(4);
  endtask

  initial begin
    reset_i     = 1'b1;
    enable_i    = 1'b0;
    reference_i = 1'b0;
    generated_i = 1'b0;
    ref_pat     = '0;
    gen_pat     = '0;
    tick(2);
    check("rst_err",   32'(err12),   0);
    check("rst_valid", 32'(valid12), 0);
    check("rst_tmo",   32'(tmo12),   0);
    check("rst_busy",  32'(busy12),  0);
    check("rst_err8",  32'(err8),    0);
    reset_i  = 1'b0;
    enable_i = 1'b1;
    tick(3);

    // Ref fine 10, gen fine 4 three cycles later: 3*15+10-4 = 51
    fire_ref(10);
    tick(1); unfire_ref();
    tick(1);
    check("a_busy_pre", 32'(busy12), 0);
    tick(1);
    check("a_busy",  32'(busy12), 1);
    check("a_busy8", 32'(busy8),  1);
    fire_gen(4);
    tick(1); unfire_gen();
    tick(2);
    check("a_busy_drop", 32'(busy12),  0);
    check("a_valid_pre", 32'(valid12), 0);
    tick(1);
    check("a_valid", 32'(valid12), 1);
    check("a_err",   32'(err12),   51);
    check("a_err8",  32'(err8),    51);
    tick(1);
    check("a_valid_post", 32'(valid12), 0);
    lower();

    // Simultaneous events, fine 7/7
    fire_ref(7);
    fire_gen(7);
    tick(1); unfire_ref(); unfire_gen();
    tick(1);
    check("c_busy_a", 32'(busy12), 0);
    tick(1);
    check("c_busy_b", 32'(busy12), 0);
    tick(1);
    check("c_valid", 32'(valid12), 1);
    check("c_err",   32'(err12),   0);
    lower();

    // Gen fine 5, ref fine 12 one cycle later: -15+12-5 = -8
    fire_gen(5);
    tick(1); unfire_gen(); fire_ref(12);
    tick(1); unfire_ref();
    tick(3);
    check("b_valid", 32'(valid12), 1);
    check("b_err",   32'(err12),   -8);
    check("b_err8",  32'(err8),    -8);
    lower();

    // Ref only: timeout after 63 cycles, error held
    fire_ref(10);
    tick(1); unfire_ref();
    tick(64);
    check("d_tmo_pre", 32'(tmo12),  0);
    check("d_busy",    32'(busy12), 1);
    tick(1);
    check("d_tmo",    32'(tmo12),   1);
    check("d_tmo8",   32'(tmo8),    1);
    check("d_valid",  32'(valid12), 0);
    check("d_busy_e", 32'(busy12),  0);
    check("d_err",    32'(err12),   -8);
    tick(1);
    check("d_tmo_post", 32'(tmo12), 0);
    lower();

    // Gen 20 cycles after ref, equal fine: 300, saturates to 127 at WIDTH=8
    fire_ref(6);
    tick(1); unfire_ref();
    tick(19);
    fire_gen(6);
    tick(1); unfire_gen();
    tick(3);
    check("e_valid",  32'(valid12), 1);
    check("e_valid8", 32'(valid8),  1);
    check("e_err",    32'(err12),   300);
    check("e_err8",   32'(err8),    127);
    lower();

    // Ref 20 cycles after gen: -300, saturates to -128 at WIDTH=8
    fire_gen(6);
    tick(1); unfire_gen();
    tick(19);
    fire_ref(6);
    tick(1); unfire_ref();
    tick(3);
    check("f_err",  32'(err12), -300);
    check("f_err8", 32'(err8),  -128);
    lower();

    // Disarm while waiting: no result, no timeout
    fire_ref(8);
    tick(1); unfire_ref();
    tick(2);
    check("h_busy", 32'(busy12), 1);
    enable_i = 1'b0;
    tick(1);
    check("h_busy_off", 32'(busy12), 0);
    fire_gen(3);
    tick(1); unfire_gen();
    tick(3);
    check("h_valid", 32'(valid12), 0);
    check("h_tmo",   32'(tmo12),   0);
    check("h_err",   32'(err12),   -300);
    enable_i = 1'b1;
    lower();

    // Reset while waiting clears outputs at once; next pair measures cleanly
    fire_ref(9);
    tick(1); unfire_ref();
    tick(2);
    check("g_busy", 32'(busy12), 1);
    reset_i     = 1'b1;
    reference_i = 1'b0;
    #1;
    check("g_err",   32'(err12),   0);
    check("g_err8",  32'(err8),    0);
    check("g_valid", 32'(valid12), 0);
    check("g_tmo",   32'(tmo12),   0);
    check("g_busy0", 32'(busy12),  0);
    tick(4);
    reset_i = 1'b0;
    tick(3);
    fire_ref(9);
    tick(1); unfire_ref();
    tick(1);
    fire_gen(2);
    tick(1); unfire_gen();
    tick(3);
    check("g2_valid", 32'(valid12), 1);
    check("g2_err",   32'(err12),   37);
    lower();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
